brick_wall_ctrl: RTL and testbench
==================================

BRICK_WALL_CTRL -- requirements
Module: brick_wall_ctrl

Interface
REQ-001 Parameter: COLS, 10, bricks per row; bit i of a row word = column i.
REQ-002 Parameter: ROWS, 4, brick rows; row 0 = top.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level-start pulse from game FSM.
REQ-006 hit_req  input  1  ball-logic collision probe; held high until hit_ack.
REQ-007 hit_row  input  2  row of probe; stable while hit_req high.
REQ-008 hit_col  input  4  column of probe; stable while hit_req high.
REQ-009 hit_ack  output  1  one-cycle acknowledge of a probe.
REQ-010 hit_valid  output  1  brick was present and is now removed; qualified by hit_ack.
REQ-011 rd_row  input  2  renderer row select.
REQ-012 rd_bits  output  COLS  registered bitmap of rd_row.
REQ-013 score  output  8  bricks destroyed since reset, saturating.
REQ-014 bricks_left  output  6  bricks remaining in current level.
REQ-015 state  output  2  FSM state: 0 IDLE, 1 LOAD, 2 PLAY, 3 CLEAR.
REQ-016 level_clear  output  1  one-cycle pulse when last brick removed.

Function
REQ-017 The block SHALL own a ROWS x COLS brick bitmap and SHALL be the only writer of it.
REQ-018 IDLE: start=1 SHALL move to LOAD next cycle; otherwise stay.
REQ-019 LOAD: one row per cycle, rows 0..ROWS-1 in order, set to all ones; after the row ROWS-1 write, state SHALL be PLAY and bricks_left SHALL be ROWS*COLS (40).
REQ-020 PLAY: bricks_left reaching 0 SHALL move to CLEAR the next cycle, with level_clear high for exactly that one cycle.
REQ-021 CLEAR: start=1 SHALL move to LOAD (reload, score kept); start in LOAD or PLAY SHALL be ignored.
REQ-022 Probe acceptance: a probe SHALL be accepted on a cycle with hit_req=1, hit_ack=0 and state != LOAD; hit_ack SHALL pulse the following cycle.
REQ-023 In LOAD, probes SHALL be stalled (no ack) until PLAY is reached; hit_req remaining high SHALL then be accepted.
REQ-024 Minimum probe spacing SHALL be 2 cycles; hit_req still high on the hit_ack cycle SHALL NOT be a new probe.
REQ-025 Accepted probe in PLAY with hit_col < COLS and bitmap bit set: clear the bit, decrement bricks_left, increment score (saturate at 255), hit_valid=1 with hit_ack.
REQ-026 Probe on an empty cell, hit_col >= COLS, or state IDLE/CLEAR: acknowledge with hit_valid=0; bitmap, score, bricks_left unchanged.
REQ-027 rd_bits SHALL equal bitmap[rd_row] sampled at the previous edge (1-cycle latency); a same-cycle clear SHALL appear one cycle later (read-before-write).
REQ-028 hit_valid SHALL be 0 whenever hit_ack is 0.
REQ-029 bricks_left SHALL never underflow; it changes only in LOAD (set) and accepted valid hits (decrement by 1).

Reset
REQ-030 rst_n low SHALL force, asynchronously: state IDLE, bitmap all zero, rd_bits 0, score 0, bricks_left 0, hit_ack 0, hit_valid 0, level_clear 0.
REQ-031 Reset mid-LOAD or mid-probe SHALL abandon the operation; no ack SHALL be issued for a probe pending at reset.
REQ-032 After rst_n release, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 Reset, pulse start -> state 1 for 4 cycles, then state 2, bricks_left=40, rd_bits=10'h3FF for every rd_row.
REQ-034 PLAY, probe row 2 col 5 -> hit_ack 1 cycle after, hit_valid=1, score=1, bricks_left=39, rd_bits(row 2)=10'h3DF; repeat same probe -> hit_valid=0, counts unchanged.
REQ-035 Probe col 12 in PLAY, and any probe in IDLE -> hit_ack with hit_valid=0, no state change.
REQ-036 Clear all 40 bricks -> level_clear pulses once on the cycle after bricks_left=0, state 3; start -> reload, score=40 retained; 255+ hits across levels -> score holds 255.
REQ-037 hit_req held high across start/LOAD -> no ack during LOAD, ack on first PLAY-accept; rst_n asserted during LOAD -> all outputs zero immediately, state 0.

Source files
------------

// File: rtl/brick_wall_ctrl.sv
// Brick-wall bitmap owner for the breakout game: level load, collision probes,
// score and remaining-brick bookkeeping, plus a registered row read port for the renderer.
module brick_wall_ctrl #(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            hit_req_i,
  input  logic [1:0]      hit_row_i,
  input  logic [3:0]      hit_col_i,
  output logic            hit_ack_o,
  output logic            hit_valid_o,
  input  logic [1:0]      rd_row_i,
  output logic [COLS-1:0] rd_bits_o,
  output logic [7:0]      score_o,
  output logic [5:0]      bricks_left_o,
  output logic [1:0]      state_o,
  output logic            level_clear_o
);

  localparam int unsigned Total   = ROWS * COLS;
  localparam logic [1:0]  LastRow = 2'(ROWS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StPlay  = 2'd2,
    StClear = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 load_row_q, load_row_d;
  logic [ROWS-1:0][COLS-1:0]  bitmap_q, bitmap_d;
  logic [COLS-1:0]            rd_bits_q, rd_bits_d;
  logic [7:0]                 score_q, score_d;
  logic [5:0]                 bricks_left_q, bricks_left_d;
  logic                       hit_ack_q, hit_ack_d;
  logic                       hit_valid_q, hit_valid_d;
  logic                       level_clear_q, level_clear_d;
  logic                       accept;

  always_comb begin
    state_d       = state_q;
    load_row_d    = load_row_q;
    bitmap_d      = bitmap_q;
    score_d       = score_q;
    bricks_left_d = bricks_left_q;
    hit_ack_d     = 1'b0;
    hit_valid_d   = 1'b0;
    level_clear_d = 1'b0;
    // Renderer sees the bitmap as it was before this cycle's write.
    rd_bits_d     = (32'(rd_row_i) < ROWS) ? bitmap_q[rd_row_i] : '0;
    // The ack cycle itself never starts a new probe, which enforces 2-cycle spacing.
    accept        = hit_req_i && !hit_ack_q && (state_q != StLoad);

    unique case (state_q)
      StIdle, StClear: begin
        if (start_i) begin
          state_d    = StLoad;
          load_row_d = 2'd0;
        end
      end
      StLoad: begin
        bitmap_d[load_row_q] = '1;
        load_row_d           = load_row_q + 2'd1;
        if (load_row_q == LastRow) begin
          state_d       = StPlay;
          bricks_left_d = 6'(Total);
        end
      end
      StPlay: begin
        if (bricks_left_q == '0) begin
          state_d       = StClear;
          level_clear_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      hit_ack_d = 1'b1;
      if ((state_q == StPlay) && (32'(hit_col_i) < COLS) && (32'(hit_row_i) < ROWS) &&
          bitmap_q[hit_row_i][hit_col_i]) begin
        hit_valid_d                      = 1'b1;
        bitmap_d[hit_row_i][hit_col_i]   = 1'b0;
        bricks_left_d                    = bricks_left_q - 6'd1;
        if (score_q != 8'hFF) score_d    = score_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      load_row_q    <= 2'd0;
      bitmap_q      <= '0;
      rd_bits_q     <= '0;
      score_q       <= 8'd0;
      bricks_left_q <= 6'd0;
      hit_ack_q     <= 1'b0;
      hit_valid_q   <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_row_q    <= load_row_d;
      bitmap_q      <= bitmap_d;
      rd_bits_q     <= rd_bits_d;
      score_q       <= score_d;
      bricks_left_q <= bricks_left_d;
      hit_ack_q     <= hit_ack_d;
      hit_valid_q   <= hit_valid_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign hit_ack_o     = hit_ack_q;
  assign hit_valid_o   = hit_valid_q;
  assign rd_bits_o     = rd_bits_q;
  assign score_o       = score_q;
  assign bricks_left_o = bricks_left_q;
  assign state_o       = state_q;
  assign level_clear_o = level_clear_q;

endmodule

// File: tb/tb_brick_wall_ctrl.sv
// Self-checking bench for brick_wall_ctrl: vector table for single probes, a scoreboard
// queue of expected ack results, and hand-written load / clear / reset sequences.
module tb_brick_wall_ctrl;

  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hit_req = 1'b0;
  logic [1:0]      hit_row = 2'd0;
  logic [3:0]      hit_col = 4'd0;
  logic [1:0]      rd_row = 2'd0;
  logic            hit_ack, hit_valid, level_clear;
  logic [COLS-1:0] rd_bits;
  logic [7:0]      score;
  logic [5:0]      bricks_left;
  logic [1:0]      state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brick_wall_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .hit_req_i    (hit_req),
    .hit_row_i    (hit_row),
    .hit_col_i    (hit_col),
    .hit_ack_o    (hit_ack),
    .hit_valid_o  (hit_valid),
    .rd_row_i     (rd_row),
    .rd_bits_o    (rd_bits),
    .score_o      (score),
    .bricks_left_o(bricks_left),
    .state_o      (state),
    .level_clear_o(level_clear)
  );

  typedef struct {
    logic       valid;
    logic [7:0] score;
    logic [5:0] left;
  } exp_t;

  typedef struct {
    logic [1:0] row;
    logic [3:0] col;
    logic       valid;
    logic [7:0] score;
    logic [5:0] left;
    logic [9:0] bits;
  } vec_t;

  exp_t            sb_q[$];
  logic [COLS-1:0] m_map[ROWS];
  logic [7:0]      m_score = 8'd0;
  logic [5:0]      m_left  = 6'd0;
  logic            m_play  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_left"}, bricks_left, 0);
    check({tag, "_ack"}, hit_ack, 0);
    check({tag, "_valid"}, hit_valid, 0);
    check({tag, "_lclear"}, level_clear, 0);
    check({tag, "_rdbits"}, rd_bits, 0);
  endtask

  task automatic model_load();
    for (int r = 0; r < ROWS; r++) m_map[r] = '1;
    m_left = 6'd40;
    m_play = 1'b1;
  endtask

  // Drive one probe; the expected ack result rides the scoreboard until the ack shows up.
  task automatic probe(input logic [1:0] r, input logic [3:0] c, input exp_t e, output int lat);
    exp_t x;
    bit   got;
    got = 1'b0;
    lat = 0;
    sb_q.push_back(e);
    hit_row = r;
    hit_col = c;
    hit_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (hit_ack) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    x = sb_q.pop_front();
    if (!got) fail_bound("probe_ack");
    else begin
      check("hit_valid", hit_valid, x.valid);
      check("score", score, x.score);
      check("bricks_left", bricks_left, x.left);
    end
    // hit_req stays high across the ack cycle edge: must not be taken as a new probe.
    tick();
    hit_req = 1'b0;
    check("ack_one_cycle", hit_ack, 0);
  endtask

  task automatic mprobe(input logic [1:0] r, input logic [3:0] c, output int lat);
    exp_t e;
    e.valid = 1'b0;
    if (m_play && (c < 4'd10)) e.valid = m_map[r][c];
    if (e.valid) begin
      m_map[r][c] = 1'b0;
      m_left      = m_left - 6'd1;
      if (m_score != 8'hFF) m_score = m_score + 8'd1;
    end
    e.score = m_score;
    e.left  = m_left;
    probe(r, c, e, lat);
  endtask

  task automatic clear_level();
    int lat;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_map[r][c]) mprobe(2'(r), 4'(c), lat);
    check("state_clear", state, 3);
    check("level_clear_hi", level_clear, 1);
    tick();
    check("level_clear_lo", level_clear, 0);
    check("state_clear_hold", state, 3);
    m_play = 1'b0;
  endtask

  task automatic wait_play(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (state == 2'd2) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) fail_bound(name);
  endtask

  task automatic reload();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_state", state, 1);
    check("reload_score_kept", score, m_score);
    wait_play("reload_play");
    check("reload_left", bricks_left, 40);
    model_load();
  endtask

  vec_t tbl[6];
  exp_t e;
  int   lat;

  initial begin
    tbl[0] = '{2'd2, 4'd5,  1'b1, 8'd1, 6'd39, 10'h3DF};
    tbl[1] = '{2'd2, 4'd5,  1'b0, 8'd1, 6'd39, 10'h3DF};
    tbl[2] = '{2'd0, 4'd12, 1'b0, 8'd1, 6'd39, 10'h3FF};
    tbl[3] = '{2'd3, 4'd0,  1'b1, 8'd2, 6'd38, 10'h3FE};
    tbl[4] = '{2'd3, 4'd9,  1'b1, 8'd3, 6'd37, 10'h1FE};
    tbl[5] = '{2'd1, 4'd15, 1'b0, 8'd3, 6'd37, 10'h3FF};
    for (int r = 0; r < ROWS; r++) m_map[r] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle_hold", state, 0);

    // Probe in IDLE: acknowledged, never valid
    mprobe(2'd0, 4'd0, lat);
    check("idle_probe_lat", lat, 1);
    check("idle_probe_state", state, 0);

    // Start and load: four LOAD cycles, then PLAY with a full wall
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_c0", state, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("load_cn", state, 1);
    end
    tick();
    check("play_after_load", state, 2);
    check("left_after_load", bricks_left, 40);
    model_load();
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 2'(r);
      tick();
      check("rd_full_row", rd_bits, 10'h3FF);
    end

    // Start during PLAY is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_play", state, 2);

    // Single-probe vectors
    foreach (tbl[i]) begin
      e.valid = tbl[i].valid;
      e.score = tbl[i].score;
      e.left  = tbl[i].left;
      probe(tbl[i].row, tbl[i].col, e, lat);
      check("probe_lat", lat, 1);
      if (tbl[i].col < 4'd10) m_map[tbl[i].row][tbl[i].col] = 1'b0;
      m_score = tbl[i].score;
      m_left  = tbl[i].left;
      rd_row  = tbl[i].row;
      tick();
      check("rd_bits_row", rd_bits, tbl[i].bits);
      check("vec_state", state, 2);
    end

    // Clear the rest of level 1, then a probe in CLEAR
    clear_level();
    mprobe(2'd1, 4'd1, lat);
    check("clear_probe_state", state, 3);

    // Reload with a probe raised during LOAD: stalled until PLAY
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload2_state", state, 1);
    check("reload2_score", score, 40);
    model_load();
    mprobe(2'd0, 4'd3, lat);
    check("load_stall_lat", lat, 5);
    clear_level();

    // Enough further levels to drive score past 255
    for (int k = 0; k < 5; k++) begin
      reload();
      clear_level();
    end
    check("score_saturated", score, 8'd255);

    // Reset in the middle of LOAD with a probe pending
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    hit_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_load_reset");
    hit_req = 1'b0;
    start   = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    check("first_start_after_reset", state, 1);
    check("no_ack_after_reset", hit_ack, 0);
    start = 1'b0;
    wait_play("post_reset_play");
    check("post_reset_left", bricks_left, 40);
    check("post_reset_score", score, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
